// File: rtl/seq_pkg.sv
// Shared definitions for the 8-word sequence generator and checker.
// Both sides take the word cycle from SEQ_WORDS so they cannot drift apart.
package seq_pkg;

    localparam int unsigned SEQ_LEN = 8;

    localparam logic [7:0] START_WORD = 8'hAF;

    localparam logic [7:0] SEQ_WORDS [SEQ_LEN] = '{
        8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
    };

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr takes priority over inc.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sequence_checker.sv
// Acquires alignment on the start word, verifies the fixed 8-word cycle and
// flywheels through isolated errors once locked.
module sequence_checker
    import seq_pkg::*;
#(
    parameter int unsigned LOCK_WORDS    = 8,
    parameter int unsigned UNLOCK_MISSES = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       data_in,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned MATCH_W = $clog2(LOCK_WORDS + 1);
    localparam logic [MATCH_W-1:0] LOCK_CNT = MATCH_W'(LOCK_WORDS);
    localparam logic [2:0] MISS_LIMIT = 3'(UNLOCK_MISSES);

    state_e             state;
    logic [2:0]         idx;
    logic [MATCH_W-1:0] match_cnt;
    logic [2:0]         miss_cnt;

    logic               hit;
    logic               err_inc;
    logic [MATCH_W-1:0] match_nxt;
    logic [2:0]         miss_nxt;

    // Both E2 entries are told apart purely by idx, so no special casing is needed.
    assign hit       = (data_in == SEQ_WORDS[idx]);
    assign match_nxt = match_cnt + 1'b1;
    assign miss_nxt  = miss_cnt + 3'd1;
    assign err_inc   = in_valid && (state == LOCKED) && !hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEARCH;
            idx        <= 3'd0;
            match_cnt  <= '0;
            miss_cnt   <= 3'd0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            if (in_valid) begin
                unique case (state)
                    SEARCH: begin
                        if (data_in == START_WORD) begin
                            state     <= VERIFY;
                            idx       <= 3'd1;
                            match_cnt <= MATCH_W'(1);
                        end
                    end
                    VERIFY: begin
                        if (hit) begin
                            idx       <= idx + 3'd1;
                            match_cnt <= match_nxt;
                            if (match_nxt == LOCK_CNT) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= 3'd0;
                            end
                        end else if (data_in == START_WORD) begin
                            idx       <= 3'd1;
                            match_cnt <= MATCH_W'(1);
                        end else begin
                            state     <= SEARCH;
                            idx       <= 3'd0;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: position advances whether or not the word matched.
                        idx <= idx + 3'd1;
                        if (hit) begin
                            miss_cnt   <= 3'd0;
                            wrap_pulse <= (idx == 3'd7);
                        end else begin
                            err_pulse <= 1'b1;
                            miss_cnt  <= miss_nxt;
                            if (miss_nxt == MISS_LIMIT) begin
                                state     <= SEARCH;
                                locked    <= 1'b0;
                                idx       <= 3'd0;
                                match_cnt <= '0;
                                miss_cnt  <= 3'd0;
                            end
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (err_inc),
        .clr  (clear_cnt),
        .count(err_count)
    );

endmodule

// File: tb/tb_sequence_checker.sv
// Drives two checker configurations from one stimulus stream and compares
// every cycle against a rule-level reference model.
module tb_sequence_checker;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  data_in;
    logic        clear_cnt;

    logic        locked0, err_pulse0, wrap_pulse0;
    logic [15:0] err_count0;
    logic        locked1, err_pulse1, wrap_pulse1;
    logic [3:0]  err_count1;

    int tests_run;
    int tests_failed;

    logic [7:0] seq_tab [8];
    int gen_pos;

    // Reference model state, index 0 = default DUT, 1 = small DUT.
    localparam int M_SEARCH = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;
    int lw   [2];
    int um   [2];
    int cmax [2];
    int m_st [2];
    int m_pos[2];
    int m_run[2];
    int m_miss[2];
    int m_cnt[2];
    bit m_err[2];
    bit m_wrap[2];

    sequence_checker u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .clear_cnt (clear_cnt),
        .locked    (locked0),
        .err_pulse (err_pulse0),
        .wrap_pulse(wrap_pulse0),
        .err_count (err_count0)
    );

    sequence_checker #(
        .LOCK_WORDS   (4),
        .UNLOCK_MISSES(7),
        .CNT_W        (4)
    ) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .clear_cnt (clear_cnt),
        .locked    (locked1),
        .err_pulse (err_pulse1),
        .wrap_pulse(wrap_pulse1),
        .err_count (err_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_st[d] = M_SEARCH;
            m_pos[d] = 0;
            m_run[d] = 0;
            m_miss[d] = 0;
            m_cnt[d] = 0;
            m_err[d] = 0;
            m_wrap[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input bit v, input logic [7:0] w, input bit clr);
        bit match;
        bit inc;
        m_err[d] = 0;
        m_wrap[d] = 0;
        inc = 0;
        if (v) begin
            match = (w == seq_tab[m_pos[d]]);
            if (m_st[d] == M_SEARCH) begin
                if (w == 8'hAF) begin
                    m_st[d] = M_VERIFY;
                    m_pos[d] = 1;
                    m_run[d] = 1;
                end
            end else if (m_st[d] == M_VERIFY) begin
                if (match) begin
                    m_pos[d] = (m_pos[d] + 1) % 8;
                    m_run[d]++;
                    if (m_run[d] == lw[d]) begin
                        m_st[d] = M_LOCKED;
                        m_miss[d] = 0;
                    end
                end else if (w == 8'hAF) begin
                    m_pos[d] = 1;
                    m_run[d] = 1;
                end else begin
                    m_st[d] = M_SEARCH;
                end
            end else begin
                if (match) begin
                    m_miss[d] = 0;
                    m_wrap[d] = (m_pos[d] == 7);
                end else begin
                    m_err[d] = 1;
                    inc = 1;
                    m_miss[d]++;
                    if (m_miss[d] == um[d]) m_st[d] = M_SEARCH;
                end
                m_pos[d] = (m_pos[d] + 1) % 8;
            end
        end
        if (clr) m_cnt[d] = 0;
        else if (inc && m_cnt[d] < cmax[d]) m_cnt[d]++;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".locked0"}, 32'(locked0), 32'(m_st[0] == M_LOCKED));
        check({tag, ".err0"}, 32'(err_pulse0), 32'(m_err[0]));
        check({tag, ".wrap0"}, 32'(wrap_pulse0), 32'(m_wrap[0]));
        check({tag, ".cnt0"}, 32'(err_count0), 32'(m_cnt[0]));
        check({tag, ".locked1"}, 32'(locked1), 32'(m_st[1] == M_LOCKED));
        check({tag, ".err1"}, 32'(err_pulse1), 32'(m_err[1]));
        check({tag, ".wrap1"}, 32'(wrap_pulse1), 32'(m_wrap[1]));
        check({tag, ".cnt1"}, 32'(err_count1), 32'(m_cnt[1]));
    endtask

    task automatic send(input string tag, input bit v, input logic [7:0] w, input bit clr);
        reset = 1'b0;
        in_valid = v;
        data_in = w;
        clear_cnt = clr;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) model_step(d, v, w, clr);
        compare_all(tag);
    endtask

    // Next generator word, optionally corrupted to a guaranteed-different value.
    task automatic send_gen(input string tag, input bit corrupt, input bit clr);
        logic [7:0] w;
        w = seq_tab[gen_pos];
        if (corrupt) w = w ^ 8'($urandom_range(1, 255));
        gen_pos = (gen_pos + 1) % 8;
        send(tag, 1'b1, w, clr);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        in_valid = 1'b1;
        data_in = 8'hAF;
        clear_cnt = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        model_reset();
        compare_all(tag);
        reset = 1'b0;
        in_valid = 1'b0;
        clear_cnt = 1'b0;
    endtask

    initial begin
        logic [7:0] false_start [12];
        int burst;
        int r;

        tests_run = 0;
        tests_failed = 0;
        seq_tab = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
        false_start = '{8'h00, 8'hAF, 8'hBC, 8'hE2, 8'hAF, 8'hBC, 8'hE2, 8'h78,
                        8'hFF, 8'hE2, 8'h0B, 8'h8D};
        lw = '{8, 4};
        um = '{3, 7};
        cmax = '{65535, 15};
        reset = 1'b1;
        in_valid = 1'b0;
        data_in = 8'h00;
        clear_cnt = 1'b0;
        gen_pos = 0;
        model_reset();

        @(posedge clk);
        do_reset("reset");

        // Clean stream
        for (int i = 1; i <= 24; i++) begin
            send_gen("clean", 1'b0, 1'b0);
            if (i == 7) check("pre_lock", 32'(locked0), 32'd0);
            if (i == 8) begin
                check("lock_at_8", 32'(locked0), 32'd1);
                check("no_wrap_at_lock", 32'(wrap_pulse0), 32'd0);
            end
            if (i == 16) check("first_wrap", 32'(wrap_pulse0), 32'd1);
        end

        // Single error: the 78 slot is replaced by 00
        for (int i = 0; i < 8; i++) begin
            if (gen_pos == 3) begin
                gen_pos = 4;
                send("single_err", 1'b1, 8'h00, 1'b0);
                check("single_err_pulse", 32'(err_pulse0), 32'd1);
            end else begin
                send_gen("single", 1'b0, 1'b0);
            end
        end
        check("single_err_cnt", 32'(err_count0), 32'd1);
        check("single_still_locked", 32'(locked0), 32'd1);

        // Loss of lock with three consecutive errors
        for (int i = 0; i < 3; i++) send_gen("loss", 1'b1, 1'b0);
        check("loss_unlocked", 32'(locked0), 32'd0);
        check("loss_cnt", 32'(err_count0), 32'd4);

        // False start then reacquire
        for (int i = 0; i < 12; i++) send("false_start", 1'b1, false_start[i], 1'b0);
        check("false_start_lock", 32'(locked0), 32'd1);
        gen_pos = 0;

        // Gaps with garbage, then clear colliding with a locked error
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) send_gen("gap_v", 1'b0, 1'b0);
            else send("gap_nv", 1'b0, 8'($urandom), 1'b0);
        end
        check("gap_lock", 32'(locked0), 32'd1);
        send_gen("clr_err", 1'b1, 1'b1);
        check("clr_win0", 32'(err_count0), 32'd0);
        check("clr_win1", 32'(err_count1), 32'd0);

        // Randomized traffic with errors, bursts, slips, clears and resets
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 2) begin
                do_reset("rand_reset");
            end else if ($urandom_range(0, 3) == 0) begin
                send("rand_gap", 1'b0, 8'($urandom), 1'($urandom_range(0, 99) == 0));
            end else begin
                if (burst == 0 && r < 10) burst = $urandom_range(2, 8);
                if (r >= 10 && r < 25) gen_pos = (gen_pos + 1) % 8;
                send_gen("rand", (burst > 0) || (r >= 25 && r < 80),
                         1'($urandom_range(0, 199) == 0));
                if (burst > 0) burst--;
            end
        end

        // Saturation in the small counter, then a mid-frame reset
        do_reset("sat_reset");
        gen_pos = 0;
        for (int i = 0; i < 16; i++) send_gen("sat_lock", 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            send_gen("sat_err", 1'b1, 1'b0);
            send_gen("sat_ok", 1'b0, 1'b0);
        end
        check("sat_hold", 32'(err_count1), 32'd15);
        check("sat_locked", 32'(locked1), 32'd1);
        check("sat_cnt0", 32'(err_count0), 32'd20);
        send_gen("mid_frame", 1'b0, 1'b0);
        do_reset("mid_reset");
        check("mid_reset_locked", 32'(locked1), 32'd0);
        check("mid_reset_cnt", 32'(err_count1), 32'd0);
        gen_pos = 3;
        for (int i = 0; i < 5; i++) send_gen("post_reset", 1'b0, 1'b0);
        check("post_reset_search", 32'(locked1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sequence_checker.md
# sequence_checker

Downstream consumer of the 8-word sequence generator: it samples the generated byte stream, acquires alignment on the start word 0xAF, and verifies every following word against the fixed cycle AF, BC, E2, 78, FF, E2, 0B, 8D. It reports lock status, flags each mismatch, and keeps a saturating error count. Together with the generator, it forms a self-checking link for the loopback and feedback test benches.

## Interface
- LOCK_WORDS, default 8: consecutive correct words (start word included) needed to declare lock; legal range 2..16.
- UNLOCK_MISSES, default 3: consecutive mismatches while locked that force loss of lock; legal range 1..7.
- CNT_W, default 16: width of the error counter.
- clk  input  1  single clock domain; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  data_in carries a new sequence word this cycle; the integrator asserts it on the cycle after each generator advance.
- data_in  input  8  sequence word from the generator.
- clear_cnt  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse for each mismatched word seen while LOCKED.
- wrap_pulse  output  1  one-cycle pulse when a correct 0x8D (index 7) is accepted in LOCKED.
- err_count  output  CNT_W  saturating count of mismatches seen while LOCKED.

## Operation
- Expected word is taken from an index register idx[2:0]. Index mapping: 0 is AF, 1 is BC, 2 is E2, 3 is 78, 4 is FF, 5 is E2, 6 is 0B, 7 is 8D. The index wraps from 7 to 0.
- All state updates occur only on cycles with in_valid=1. With in_valid=0, everything holds, and err_pulse and wrap_pulse are 0.
- States:
  - SEARCH:
    - data_in==AF: go to VERIFY, idx=1, match_cnt=1.
    - Any other word: stay in SEARCH.
  - VERIFY:
    - data_in matches expected: idx advances, match_cnt increments. When match_cnt reaches LOCK_WORDS, go to LOCKED and clear miss_cnt.
    - Mismatch with data_in==AF: stay in VERIFY, idx=1, match_cnt=1 (realign).
    - Mismatch with any other word: go to SEARCH.
  - LOCKED (flywheel):
    - idx advances on every valid word, match or not.
    - Match: miss_cnt=0.
    - Mismatch: err_pulse=1, err_count increments, miss_cnt increments.
    - miss_cnt reaching UNLOCK_MISSES: go to SEARCH. The error on that word is still counted.
- The two E2 entries are distinguished only by idx; a repeated E2 never causes realignment.
- err_count:
  - Saturates at all-ones.
  - clear_cnt sets it to 0.
  - If clear_cnt coincides with a counted error, clear wins and the result is 0.
- Reset values: state=SEARCH, idx=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, wrap_pulse=0, err_count=0. Asserting reset mid-operation overrides in_valid and clear_cnt and returns every register to these values at the next edge.

## Timing
- All outputs are registered. Latency is one cycle: a valid word sampled at edge N is reflected in locked, err_pulse, wrap_pulse and err_count after edge N.
- The word that completes the lock does not produce wrap_pulse. The first wrap_pulse appears on the first correct 8D accepted in LOCKED.
- Throughput is one word per cycle; in_valid may be held high continuously.
- locked falls one cycle after the UNLOCK_MISSES-th consecutive mismatch is sampled, in the same cycle as that word's err_pulse.

## Structure
- Shared package seq_pkg:
  - SEQ_LEN=8.
  - The 8-entry constant word table SEQ_WORDS, shared with the generator so both use one definition.
  - State enum {SEARCH, VERIFY, LOCKED}.
- One natural sub-module, sat_counter: CNT_W-bit saturating counter with inc and clr inputs and clr priority. It implements err_count.
- The rest is a single always block containing the FSM, idx, match_cnt and miss_cnt, plus registered outputs.

## Test plan
- Clean stream: reset, then continuous in_valid with AF,BC,E2,78,FF,E2,0B,8D repeated. Required: locked=1 after the 8th word; first wrap_pulse on the 16th word; err_count stays 0.
- False start: stream 00,AF,BC,E2,AF,BC,E2,78,FF,E2,0B,8D. Required: the second AF realigns; locked asserts after the final 8D; err_count=0.
- Single error while locked: replace one 78 with 00. Required: one err_pulse; err_count=1; locked stays 1; the next word FF matches via the flywheel.
- Loss of lock, default parameters: 3 consecutive corrupted words while locked. Required: 3 err_pulses; err_count=3; locked=0 one cycle after the third. A later AF begins reacquisition.
- Gaps and clear: toggle in_valid randomly with in_valid=0 words set to garbage. Required: no effect on lock. Assert clear_cnt in the same cycle as a locked mismatch. Required: err_count=0.
- Saturation and reset: CNT_W=4 with 20 errors while locked and UNLOCK_MISSES=7, errors interleaved with matches. Required: err_count holds at 15. Then assert reset for 1 cycle mid-frame. Required: all outputs 0 and state SEARCH at the next edge.
